// File: rtl/mac_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mac_tx_arbiter                                                    |
// | Brief  : packet-granular round-robin arbiter feeding the MAC TX stream,    |
// |          with a registered two-entry skid output stage.                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mac_tx_arbiter #(
  parameter  int N_PORTS   = 4,
  // Symbol geometry mirrors cmn_params and is fixed for this block.
  localparam int N_SYMBOLS = 8,
  localparam int W_SYMBOL  = 8,
  localparam int W_GRANT   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                                          i_tx_clk,
  input  logic                                          i_tx_reset_n,
  input  logic [N_PORTS-1:0]                            s_axis_tvalid,
  input  logic [N_PORTS-1:0][N_SYMBOLS-1:0][W_SYMBOL-1:0] s_axis_tdata,
  input  logic [N_PORTS-1:0][N_SYMBOLS-1:0]             s_axis_tkeep,
  input  logic [N_PORTS-1:0]                            s_axis_tlast,
  output logic [N_PORTS-1:0]                            s_axis_tready,
  output logic                                          m_axis_tvalid,
  output logic [N_SYMBOLS-1:0][W_SYMBOL-1:0]            m_axis_tdata,
  output logic [N_SYMBOLS-1:0]                          m_axis_tkeep,
  output logic                                          m_axis_tlast,
  input  logic                                          m_axis_tready,
  output logic [W_GRANT-1:0]                            o_grant,
  output logic                                          o_busy
);

  typedef logic [N_SYMBOLS-1:0][W_SYMBOL-1:0] data_t;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PKT = 1'b1} state_t;

  state_t                 r_state;
  logic [W_GRANT-1:0]     r_rr_ptr;
  logic [W_GRANT-1:0]     r_grant;
  logic                   r_busy;
  logic [N_PORTS-1:0]     r_s_tready;

  logic                   r_out_valid;
  data_t                  r_out_data;
  logic [N_SYMBOLS-1:0]   r_out_keep;
  logic                   r_out_last;
  logic                   r_ovf_valid;
  data_t                  r_ovf_data;
  logic [N_SYMBOLS-1:0]   r_ovf_keep;
  logic                   r_ovf_last;

  logic [W_GRANT-1:0]     w_sel_hi;
  logic [W_GRANT-1:0]     w_sel_lo;
  logic                   w_hit_hi;
  logic [W_GRANT-1:0]     w_sel;
  logic                   w_any_req;
  logic [W_GRANT-1:0]     w_gnt_inc;
  data_t                  w_in_data;
  logic [N_SYMBOLS-1:0]   w_in_keep;
  logic                   w_in_last;
  logic                   w_acc;
  logic                   w_pop;
  logic                   w_next_full;

  // Ports at or above the pointer win over those below it, lowest index first.
  always_comb begin
    w_sel_hi = '0;
    w_sel_lo = '0;
    w_hit_hi = 1'b0;
    for (int j = N_PORTS-1; j >= 0; j--) begin
      if (s_axis_tvalid[j]) begin
        if (j >= int'(r_rr_ptr)) begin
          w_sel_hi = j[W_GRANT-1:0];
          w_hit_hi = 1'b1;
        end else begin
          w_sel_lo = j[W_GRANT-1:0];
        end
      end
    end
  end

  assign w_sel     = w_hit_hi ? w_sel_hi : w_sel_lo;
  assign w_any_req = |s_axis_tvalid;
  assign w_gnt_inc = (int'(r_grant) == N_PORTS-1) ? '0 : r_grant + W_GRANT'(1);

  assign w_in_data = s_axis_tdata[r_grant];
  assign w_in_keep = s_axis_tkeep[r_grant];
  assign w_in_last = s_axis_tlast[r_grant];

  // Only the granted bit of r_s_tready can ever be set.
  assign w_acc       = |(s_axis_tvalid & r_s_tready);
  assign w_pop       = r_out_valid & m_axis_tready;
  assign w_next_full = ~w_pop & (r_ovf_valid | (r_out_valid & w_acc));

  always_ff @(posedge i_tx_clk or negedge i_tx_reset_n) begin
    if (!i_tx_reset_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_s_tready <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state    <= ST_PKT;
            r_grant    <= w_sel;
            r_busy     <= 1'b1;
            r_s_tready <= (N_PORTS'(1) << w_sel) & {N_PORTS{~w_next_full}};
          end
        end
        ST_PKT: begin
          if (w_acc && w_in_last) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_rr_ptr   <= w_gnt_inc;
            r_s_tready <= '0;
          end else begin
            r_s_tready <= (N_PORTS'(1) << r_grant) & {N_PORTS{~w_next_full}};
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_s_tready <= '0;
        end
      endcase
    end
  end

  // Overflow entry is only ever occupied while the output register is too.
  always_ff @(posedge i_tx_clk or negedge i_tx_reset_n) begin
    if (!i_tx_reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_ovf_valid <= 1'b0;
      r_ovf_data  <= '0;
      r_ovf_keep  <= '0;
      r_ovf_last  <= 1'b0;
    end else begin
      if (w_pop || !r_out_valid) begin
        if (r_ovf_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_ovf_data;
          r_out_keep  <= r_ovf_keep;
          r_out_last  <= r_ovf_last;
          r_ovf_valid <= 1'b0;
        end else if (w_acc) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_in_data;
          r_out_keep  <= w_in_keep;
          r_out_last  <= w_in_last;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_acc) begin
        r_ovf_valid <= 1'b1;
        r_ovf_data  <= w_in_data;
        r_ovf_keep  <= w_in_keep;
        r_ovf_last  <= w_in_last;
      end
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tkeep  = r_out_keep;
  assign m_axis_tlast  = r_out_last;
  assign o_grant       = r_grant;
  assign o_busy        = r_busy;

endmodule
`default_nettype wire
